muu_mufifo_sched: RTL
=====================

# muu_mufifo_sched

Round-robin drain scheduler for the multi-user FIFO. It tracks per-user word occupancy by observing enqueue handshakes and dequeue handshakes. It selects which user queue the multi-user FIFO presents on its master side and drives that FIFO's master ready. Data bypasses this block; it sits between the multi-user FIFO master port and the downstream consumer and handles control only.

## Interface
- USER_BITS, 3, user select width; 2**USER_BITS queues
- CNT_BITS, 6, per-queue occupancy counter width; must exceed queue address bits by at least 1
- MAX_BURST, 8, maximum words drained from one user before re-arbitration (1..2**CNT_BITS-1)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enq_valid  in  1  write-side tvalid into the multi-user FIFO
- enq_ready  in  1  write-side tready from the multi-user FIFO
- enq_user  in  USER_BITS  write-side user select, as registered by the FIFO
- mufifo_tvalid  in  1  multi-user FIFO m_axis_tvalid
- mufifo_tready  out  1  drives multi-user FIFO m_axis_tready
- mufifo_tusersel  out  USER_BITS  drives multi-user FIFO m_axis_tusersel
- out_tvalid  out  1  valid to consumer
- out_tready  in  1  ready from consumer
- out_tuser  out  USER_BITS  user id of the current word (equals mufifo_tusersel)
- err  out  1  sticky counter overflow/underflow flag

## Operation
- Enqueue event: enq_valid & enq_ready. cnt[enq_user] +1.
- Dequeue event: mufifo_tvalid & mufifo_tready. cnt[sel] −1.
- Both events on the same user in one cycle: that counter is unchanged.
- Increment at all-ones, or decrement at 0: the counter holds its value and err is set to 1 until reset.
- State machine has three states: IDLE, SWITCH, DRAIN.
- IDLE:
  - mufifo_tready=0, out_tvalid=0.
  - If any cnt[u]>0: search from last+1 upward, modulo 2**USER_BITS. Load sel with the first nonzero u, set last=u, clear burst, go to SWITCH.
  - Otherwise stay in IDLE.
- SWITCH: exactly 1 cycle, mufifo_tready=0. The multi-user FIFO latches its usersel only while its tready is low, so this cycle is mandatory. Next state is DRAIN.
- DRAIN:
  - mufifo_tready=out_tready; out_tvalid=mufifo_tvalid.
  - Each dequeue event increments burst.
  - Exit to IDLE at the clock edge ending a dequeue event where burst+1==MAX_BURST, or where cnt[sel] becomes 0 (it was 1 and there is no same-user enqueue).
  - While cnt[sel]>0 and mufifo_tvalid=0 (FIFO pipeline latency), stay in DRAIN and wait.
- A single nonempty user is reselected after its burst, paying the 2-cycle IDLE+SWITCH bubble.
- Counters are the sole source of the nonempty status; the FIFO's almostfull signal is not used.

## Timing
- Reset values:
  - state=IDLE, sel=0, last=2**USER_BITS−1 (so the first search starts at user 0).
  - all cnt=0, burst=0, err=0.
  - mufifo_tready=0, out_tvalid=0, mufifo_tusersel=0, out_tuser=0.
- Reset is effective immediately and asynchronously. Reset mid-DRAIN drops mufifo_tready the same instant. The multi-user FIFO must be reset together with this block; queued words are discarded.
- sel, state, counters and err are registered. mufifo_tready and out_tvalid are combinational from state, out_tready and mufifo_tvalid only.
- First-word latency, enqueue at cycle 0 into empty queues:
  - cycle 1: cnt=1, IDLE decides.
  - cycle 2: SWITCH, mufifo_tusersel updated.
  - cycle 3: DRAIN, earliest out_tvalid.
- Inter-user switch overhead is 2 cycles (IDLE + SWITCH) with mufifo_tready=0.
- Sustained throughput within a burst is 1 word/cycle when out_tready=1 and the FIFO is valid.
- AXI-stream rules toward the consumer: once asserted, out_tvalid holds with unchanged out_tuser until out_tready=1.

## Test plan
- Reset, then enqueue 3 words to user 2 → cycle 3 first out_tvalid with out_tuser=2. Three consecutive transfers under out_tready=1, then IDLE. err=0.
- Users 0, 1, 5 each hold 20 words, MAX_BURST=8, out_tready=1 → grant order 0(8), 1(8), 5(8), 0(8), 1(8), 5(8), 0(4), 1(4), 5(4), with 2 idle cycles between bursts.
- Only user 7 holds 10 words → bursts of 8 then 2, both user 7, with a 2-cycle gap. mufifo_tready=0 during the gap.
- In DRAIN for user 4 with cnt=1, enqueue to user 4 in the same cycle as the dequeue → cnt stays 1, DRAIN continues, next word delivered.
- out_tready=0 for 5 cycles mid-burst → out_tvalid and out_tuser held, burst count unchanged, no dequeue events counted.
- Assert rst low during DRAIN after 3 of 8 words → outputs go to reset values immediately. After release, counters are 0, err=0, and there is no out_tvalid until a new enqueue.

Source files
------------

// File: rtl/muu_mufifo_sched_if.sv
// Control-side signals of the multi-user FIFO drain scheduler: enqueue monitor,
// FIFO master-side handshake and consumer-side handshake.
interface muu_mufifo_sched_if #(
  parameter int unsigned USER_BITS = 3
) ();
  logic                 enq_valid;
  logic                 enq_ready;
  logic [USER_BITS-1:0] enq_user;
  logic                 mufifo_tvalid;
  logic                 mufifo_tready;
  logic [USER_BITS-1:0] mufifo_tusersel;
  logic                 out_tvalid;
  logic                 out_tready;
  logic [USER_BITS-1:0] out_tuser;

  // Scheduler view.
  modport master (
    input  enq_valid, enq_ready, enq_user, mufifo_tvalid, out_tready,
    output mufifo_tready, mufifo_tusersel, out_tvalid, out_tuser
  );

  // Environment view (FIFO plus consumer).
  modport slave (
    output enq_valid, enq_ready, enq_user, mufifo_tvalid, out_tready,
    input  mufifo_tready, mufifo_tusersel, out_tvalid, out_tuser
  );
endinterface

// File: rtl/muu_mufifo_sched.sv
// Round-robin drain scheduler for the multi-user FIFO: tracks per-user occupancy
// from enqueue/dequeue handshakes and steers the FIFO's user select and master ready.
module muu_mufifo_sched #(
  parameter int unsigned USER_BITS = 3,
  parameter int unsigned CNT_BITS  = 6,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  muu_mufifo_sched_if.master bus,
  output logic               err
);
  localparam int unsigned NUsers = 2 ** USER_BITS;
  localparam logic [CNT_BITS-1:0] BurstMax = CNT_BITS'(MAX_BURST);
  localparam logic [CNT_BITS-1:0] CntOne   = CNT_BITS'(1);

  typedef enum logic [1:0] {StIdle, StSwitch, StDrain} state_e;

  state_e               state_q, state_d;
  logic [USER_BITS-1:0] sel_q, sel_d;
  logic [USER_BITS-1:0] last_q, last_d;
  logic [CNT_BITS-1:0]  burst_q, burst_d;
  logic [CNT_BITS-1:0]  cnt_q [NUsers];
  logic [CNT_BITS-1:0]  cnt_d [NUsers];
  logic                 err_q, err_d;

  logic                 enq_ev, deq_ev, enq_on_sel;
  logic [NUsers-1:0]    inc_vec, dec_vec;
  logic                 found;
  logic [USER_BITS-1:0] pick;

  assign bus.mufifo_tready   = (state_q == StDrain) & bus.out_tready;
  assign bus.out_tvalid      = (state_q == StDrain) & bus.mufifo_tvalid;
  assign bus.mufifo_tusersel = sel_q;
  assign bus.out_tuser       = sel_q;
  assign err                 = err_q;

  assign enq_ev     = bus.enq_valid & bus.enq_ready;
  assign deq_ev     = bus.mufifo_tvalid & bus.mufifo_tready;
  assign enq_on_sel = enq_ev & (bus.enq_user == sel_q);
  assign inc_vec    = enq_ev ? (NUsers'(1) << bus.enq_user) : '0;
  assign dec_vec    = deq_ev ? (NUsers'(1) << sel_q) : '0;

  // Occupancy counters saturate; any over/underflow attempt is flagged sticky.
  always_comb begin
    err_d = err_q;
    for (int u = 0; u < NUsers; u++) begin
      cnt_d[u] = cnt_q[u];
      if (inc_vec[u] && !dec_vec[u]) begin
        if (cnt_q[u] == '1) err_d = 1'b1;
        else                cnt_d[u] = cnt_q[u] + CntOne;
      end else if (dec_vec[u] && !inc_vec[u]) begin
        if (cnt_q[u] == '0) err_d = 1'b1;
        else                cnt_d[u] = cnt_q[u] - CntOne;
      end
    end
  end

  // Round-robin search starting just after the last granted user.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUsers; i++) begin
      if (!found && (cnt_q[last_q + USER_BITS'(i)] != '0)) begin
        found = 1'b1;
        pick  = last_q + USER_BITS'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          sel_d   = pick;
          last_d  = pick;
          burst_d = '0;
          state_d = StSwitch;
        end
      end
      // FIFO latches usersel only while its tready is low.
      StSwitch: state_d = StDrain;
      StDrain: begin
        if (deq_ev) begin
          burst_d = burst_q + CntOne;
          if ((burst_d == BurstMax) || ((cnt_q[sel_q] == CntOne) && !enq_on_sel)) begin
            state_d = StIdle;
          end
        end else if (cnt_q[sel_q] == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      last_q  <= '1;
      burst_q <= '0;
      err_q   <= 1'b0;
      for (int u = 0; u < NUsers; u++) cnt_q[u] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      for (int u = 0; u < NUsers; u++) cnt_q[u] <= cnt_d[u];
    end
  end
endmodule
